// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over VALID/READY and emits it
// one bit per CLK with FRAME/DONE qualifiers. Define SERIAL_PARITY_EN to append an even-parity bit.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             VALID,
   output logic             READY,
   output logic             O,
   output logic             FRAME,
   output logic             DONE
);

`ifdef SERIAL_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sreg, sreg_next, sreg_shift;
   logic [CW-1:0]    cnt, cnt_next;
   logic             o_next, frame_next;
   logic             last, accept;
`ifdef SERIAL_PARITY_EN
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
   logic             par, par_next;
`endif

   assign last       = (cnt == LAST);
   assign READY      = (state == IDLE) || ((state == SHIFT) && last);
   assign DONE       = FRAME && last;
   assign accept     = VALID && READY;
   // The bit to emit next always sits at the output end of the shifted register.
   assign sreg_shift = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_next = state;
      sreg_next  = sreg;
      cnt_next   = cnt;
      o_next     = O;
      frame_next = FRAME;
`ifdef SERIAL_PARITY_EN
      par_next   = par;
`endif
      if (accept) begin
         state_next = SHIFT;
         sreg_next  = DATA_IN;
         cnt_next   = '0;
         o_next     = MSB_FIRST ? DATA_IN[WIDTH-1] : DATA_IN[0];
         frame_next = 1'b1;
`ifdef SERIAL_PARITY_EN
         par_next   = ^DATA_IN;
`endif
      end else if (state == SHIFT) begin
         if (!last) begin
            cnt_next  = cnt + CW'(1);
            sreg_next = sreg_shift;
            o_next    = MSB_FIRST ? sreg_shift[WIDTH-1] : sreg_shift[0];
`ifdef SERIAL_PARITY_EN
            if (cnt == LAST_DATA) o_next = par;
`endif
         end else begin
            state_next = IDLE;
            frame_next = 1'b0;
            o_next     = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         O     <= 1'b0;
         FRAME <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         sreg  <= sreg_next;
         cnt   <= cnt_next;
         O     <= o_next;
         FRAME <= frame_next;
`ifdef SERIAL_PARITY_EN
         par   <= par_next;
`endif
      end
   end

endmodule
